bin2bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter using iterative shift-and-add-3 (double dabble), one bit per clock.
- Sits directly upstream of the per-digit 7-segment decoders in the bin2BCDdisplay path.
- Each 4-bit digit of its registered output drives one decoder input.
- Start/busy/done handshake; result and leading-zero blanking mask are held stable between conversions.

---
 rtl/bin2bcd_seq_pkg.sv | 35 +++
 rtl/bin2bcd_seq_add3.sv | 12 +
 rtl/bin2bcd_seq.sv | 107 ++++++++++
 tb/tb_bin2bcd_seq.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_seq_pkg.sv
// Shared constants, FSM encoding and elaboration helpers for the binary-to-BCD converter.
package bin2bcd_seq_pkg;

    localparam int unsigned BCD_W       = 4;
    localparam int unsigned ADD3_THRESH = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'(1) << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

    // True when 10^digits exceeds the largest width-bit unsigned value.
    function automatic bit range_ok(input int unsigned width, input int unsigned digits);
        longint unsigned maxv;
        longint unsigned p;
        maxv = (width >= 63) ? 64'h7fff_ffff_ffff_ffff : ((64'(1) << width) - 64'(1));
        p    = 64'(1);
        for (int unsigned i = 0; i < digits; i++) begin
            if (p > maxv) break;
            p = p * 64'(10);
        end
        return p > maxv;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble correction cell: adds 3 to a BCD digit of 5 or more.
module bcd_add3_cell
    import bin2bcd_seq_pkg::*;
(
    input  logic [BCD_W-1:0] din,
    output logic [BCD_W-1:0] dout_c
);

    // Digits >= 5 would exceed 9 after doubling, so pre-correct them.
    assign dout_c = (din >= BCD_W'(ADD3_THRESH)) ? (din + BCD_W'(3)) : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one double-dabble step per clock,
// with start/busy/done handshake and a leading-zero blanking mask.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank
);

    localparam int unsigned SCR_W     = BCD_W * DIGITS;
    localparam int unsigned CNT_RAW   = clog2(WIDTH);
    localparam int unsigned CNT_W     = (CNT_RAW < 1) ? 1 : CNT_RAW;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    // Reject configurations whose digit count cannot hold the largest input.
    generate
        if (!range_ok(WIDTH, DIGITS)) begin : g_range_err
            $error("bin2bcd_seq: 10**DIGITS must exceed 2**WIDTH-1");
        end
    endgenerate

    state_t               state;
    logic [WIDTH-1:0]     bin_q;
    logic [SCR_W-1:0]     scratch;
    logic [CNT_W-1:0]     cnt;

    logic [SCR_W-1:0]     adj_c;
    logic [SCR_W-1:0]     shifted_c;
    logic [DIGITS-1:0]    blank_nxt_c;

    // Per-digit add-3 correction on the scratch register, no inter-digit carry.
    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_add3
            bcd_add3_cell u_add3 (
                .din    (scratch[g*BCD_W +: BCD_W]),
                .dout_c (adj_c[g*BCD_W +: BCD_W])
            );
        end
    endgenerate

    // Corrected scratch shifted left, pulling in the next binary MSB.
    assign shifted_c = {adj_c[SCR_W-2:0], bin_q[WIDTH-1]};

    // Leading-zero mask from the post-shift result; units digit never blanked.
    always_comb begin
        logic all_zero;
        blank_nxt_c = '0;
        all_zero    = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            all_zero       = all_zero & (shifted_c[i*BCD_W +: BCD_W] == '0);
            blank_nxt_c[i] = all_zero;
        end
    end

    // Handshake FSM, shift datapath and registered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bin_q   <= '0;
            scratch <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd     <= '0;
            blank   <= ~DIGITS'(1);
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_q   <= bin;
                        scratch <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= shifted_c;
                    bin_q   <= bin_q << 1;
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == LAST_CNT) begin
                        bcd   <= shifted_c;
                        blank <= blank_nxt_c;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed cases plus random values
// compared with a division-based decimal reference.
module tb_bin2bcd_seq;

    logic        clk;
    logic        rst;

    logic        s8;
    logic [7:0]  b8;
    logic        busy8, done8;
    logic [11:0] bcd8;
    logic [2:0]  blank8;

    logic        s10;
    logic [9:0]  b10;
    logic        busy10, done10;
    logic [15:0] bcd10;
    logic [3:0]  blank10;

    int total;
    int bad;

    bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (s8),
        .bin   (b8),
        .busy  (busy8),
        .done  (done8),
        .bcd   (bcd8),
        .blank (blank8)
    );

    bin2bcd_seq #(.WIDTH(10), .DIGITS(4)) u_dut10 (
        .clk   (clk),
        .rst   (rst),
        .start (s10),
        .bin   (b10),
        .busy  (busy10),
        .done  (done10),
        .bcd   (bcd10),
        .blank (blank10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Decimal digits by repeated division, packed one digit per nibble.
    function automatic logic [31:0] ref_bcd(input int v, input int digits);
        logic [31:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < digits; i++) begin
            r = r | (32'((v / p) % 10) << (4 * i));
            p = p * 10;
        end
        return r;
    endfunction

    // Digit i (i>=1) is a leading zero exactly when v < 10^i.
    function automatic logic [31:0] ref_blank(input int v, input int digits);
        logic [31:0] r;
        int p;
        r = '0;
        p = 10;
        for (int i = 1; i < digits; i++) begin
            if (v < p) r[i] = 1'b1;
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] o_bcd(input int sel);
        return (sel != 0) ? 32'(bcd10) : 32'(bcd8);
    endfunction
    function automatic logic [31:0] o_blank(input int sel);
        return (sel != 0) ? 32'(blank10) : 32'(blank8);
    endfunction
    function automatic logic o_busy(input int sel);
        return (sel != 0) ? busy10 : busy8;
    endfunction
    function automatic logic o_done(input int sel);
        return (sel != 0) ? done10 : done8;
    endfunction

    // One conversion: start pulse, bounded wait for done, then latency,
    // busy duration, output hold and result checks. Returns in the done cycle.
    task automatic conv(input int sel, input int v, input int inject, input string tag);
        int          w;
        int          d;
        int          cyc;
        int          busyn;
        bit          held;
        logic [31:0] prev_bcd;
        logic [31:0] prev_blank;
        w          = (sel != 0) ? 10 : 8;
        d          = (sel != 0) ? 4 : 3;
        prev_bcd   = o_bcd(sel);
        prev_blank = o_blank(sel);
        cyc        = 0;
        busyn      = 0;
        held       = 1'b1;
        if (sel != 0) begin s10 = 1'b1; b10 = 10'(v); end
        else          begin s8  = 1'b1; b8  = 8'(v);  end
        @(posedge clk); #1;
        s8  = 1'b0;
        s10 = 1'b0;
        b8  = 8'($urandom);
        b10 = 10'($urandom);
        chk({tag, "_accept_busy"}, 32'(o_busy(sel)), 32'd1);
        chk({tag, "_accept_done"}, 32'(o_done(sel)), 32'd0);
        if (o_busy(sel)) busyn++;
        while (!o_done(sel) && cyc < 40) begin
            if (inject >= 0 && sel == 0) begin
                if (cyc == 2) begin s8 = 1'b1; b8 = 8'(inject); end
                else          begin s8 = 1'b0; end
            end
            @(posedge clk); #1;
            cyc++;
            if (o_busy(sel)) busyn++;
            if (!o_done(sel) && (o_bcd(sel) !== prev_bcd || o_blank(sel) !== prev_blank))
                held = 1'b0;
        end
        s8 = 1'b0;
        chk({tag, "_latency"},   32'(cyc),          32'(w));
        chk({tag, "_busy_len"},  32'(busyn),        32'(w));
        chk({tag, "_held"},      32'(held),         32'd1);
        chk({tag, "_bcd"},       o_bcd(sel),        ref_bcd(v, d));
        chk({tag, "_blank"},     o_blank(sel),      ref_blank(v, d));
        chk({tag, "_busy_done"}, 32'(o_busy(sel)),  32'd0);
    endtask

    task automatic step_done_low(input int sel, input string tag);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 32'(o_done(sel)), 32'd0);
    endtask

    initial begin
        int dcount;
        int v;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        s8    = 1'b0;
        s10   = 1'b0;
        b8    = '0;
        b10   = '0;

        // Reset and idle
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",  32'(busy8),  32'd0);
        chk("rst_done",  32'(done8),  32'd0);
        chk("rst_bcd",   32'(bcd8),   32'h000);
        chk("rst_blank", 32'(blank8), 32'b110);
        chk("rst_blank10", 32'(blank10), 32'b1110);
        rst    = 1'b0;
        dcount = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done8 || done10) dcount++;
        end
        chk("idle_no_done", 32'(dcount), 32'd0);
        chk("idle_bcd", 32'(bcd8), 32'h000);

        // Maximum value and leading-zero cases
        conv(0, 255, -1, "max255");
        step_done_low(0, "max255");
        conv(0, 7, -1, "v7");
        step_done_low(0, "v7");
        conv(0, 42, -1, "v42");
        step_done_low(0, "v42");
        conv(0, 0, -1, "v0");
        step_done_low(0, "v0");

        // Start while busy is ignored; start in done cycle is accepted
        conv(0, 99, 200, "busy99");
        conv(0, 128, -1, "b2b128");
        step_done_low(0, "b2b128");

        // Reset mid-conversion, concurrent start dropped
        s8 = 1'b1;
        b8 = 8'd255;
        @(posedge clk); #1;
        s8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        s8  = 1'b1;
        b8  = 8'd77;
        @(posedge clk); #1;
        rst = 1'b0;
        s8  = 1'b0;
        chk("abort_busy",  32'(busy8),  32'd0);
        chk("abort_done",  32'(done8),  32'd0);
        chk("abort_bcd",   32'(bcd8),   32'h000);
        chk("abort_blank", 32'(blank8), 32'b110);
        dcount = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done8) dcount++;
        end
        chk("abort_no_done", 32'(dcount), 32'd0);
        conv(0, 13, -1, "after_abort13");
        step_done_low(0, "after_abort13");

        // Random values on the 8-bit instance
        for (int i = 0; i < 50; i++) begin
            v = int'($urandom_range(0, 255));
            conv(0, v, -1, "rand8");
        end
        step_done_low(0, "rand8_end");

        // Wider configuration: boundaries then random
        conv(1, 0,    -1, "w10_0");
        conv(1, 1,    -1, "w10_1");
        conv(1, 999,  -1, "w10_999");
        conv(1, 1000, -1, "w10_1000");
        conv(1, 1023, -1, "w10_1023");
        step_done_low(1, "w10_1023");
        for (int i = 0; i < 1000; i++) begin
            v = int'($urandom_range(0, 1023));
            conv(1, v, -1, "rand10");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
